// File: rtl/stream_pkg.sv
// Shared types and constants for the two-way stream fork and its per-branch buffer.
package stream_pkg;

    typedef logic [1:0] cnt2_t;

    localparam int unsigned SKID_DEPTH = 2;
    localparam cnt2_t       CNT_FULL   = cnt2_t'(SKID_DEPTH);

    function automatic logic cnt_full(input cnt2_t c);
        return c == CNT_FULL;
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry FIFO used per fork branch; head beat and fill count come straight from registers.
module stream_skid2
    import stream_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output cnt2_t         count
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    cnt2_t         r_count;

    logic          w_push_ok;
    logic          w_pop_ok;
    cnt2_t         w_after_pop;
    cnt2_t         w_count_d;
    logic [DW-1:0] w_head_d;
    logic [DW-1:0] w_tail_d;

    always_comb begin
        w_push_ok   = push && !cnt_full(r_count);
        w_pop_ok    = pop && (r_count != '0);
        w_after_pop = r_count - cnt2_t'(w_pop_ok);
        w_head_d    = r_head;
        w_tail_d    = r_tail;
        if (w_pop_ok) begin
            w_head_d = r_tail;
        end
        // New beat lands in the first slot left free after this cycle's pop.
        if (w_push_ok) begin
            if (w_after_pop == '0) begin
                w_head_d = din;
            end else begin
                w_tail_d = din;
            end
        end
        w_count_d = w_after_pop + cnt2_t'(w_push_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_d;
            r_tail  <= w_tail_d;
            r_count <= w_count_d;
        end
    end

    assign dout  = r_head;
    assign count = r_count;

endmodule

// File: rtl/stream_fork2.sv
// Duplicates every accepted input beat onto two independently draining output branches.
module stream_fork2
    import stream_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o0_valid,
    input  logic          o0_ready,
    output logic [DW-1:0] o0_data,
    output logic          o1_valid,
    input  logic          o1_ready,
    output logic [DW-1:0] o1_data
);

    cnt2_t w_cnt0;
    cnt2_t w_cnt1;
    logic  w_push;
    logic  w_pop0;
    logic  w_pop1;

    // Ready depends only on registered counts, never on downstream ready or i_valid.
    assign i_ready  = reset_n && !cnt_full(w_cnt0) && !cnt_full(w_cnt1);
    assign w_push   = i_valid && i_ready;
    assign o0_valid = (w_cnt0 != '0);
    assign o1_valid = (w_cnt1 != '0);
    assign w_pop0   = o0_valid && o0_ready;
    assign w_pop1   = o1_valid && o1_ready;

    stream_skid2 #(
        .DW (DW)
    ) u_skid0 (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop0),
        .din     (i_data),
        .dout    (o0_data),
        .count   (w_cnt0)
    );

    stream_skid2 #(
        .DW (DW)
    ) u_skid1 (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop1),
        .din     (i_data),
        .dout    (o1_data),
        .count   (w_cnt1)
    );

endmodule

// File: tb/tb_stream_fork2.sv
// Directed self-checking bench for stream_fork2: reset, streaming, stall, hold and mid-run reset.
module tb_stream_fork2;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset_n;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          o0_valid;
    logic          o0_ready;
    logic [DW-1:0] o0_data;
    logic          o1_valid;
    logic          o1_ready;
    logic [DW-1:0] o1_data;

    int n_checks = 0;
    int n_errors = 0;

    stream_fork2 #(
        .DW (DW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .o0_data  (o0_data),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .o1_data  (o1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        i_valid  = 1'b1;
        i_data   = 32'h77;
        o0_ready = 1'b1;
        o1_ready = 1'b1;

        // Reset held 3 cycles with i_valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("rst_i_ready", i_ready, 1'b0);
            chk1("rst_o0_valid", o0_valid, 1'b0);
            chk1("rst_o1_valid", o1_valid, 1'b0);
        end
        chkd("rst_o0_data", o0_data, 32'h0);
        chkd("rst_o1_data", o1_data, 32'h0);
        i_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk1("post_rst_i_ready", i_ready, 1'b1);

        // Streaming 0x1..0x10 with both branches ready
        for (int k = 1; k <= 16; k++) begin
            i_valid = 1'b1;
            i_data  = k;
            #1;
            chk1("stream_i_ready", i_ready, 1'b1);
            tick();
            chk1("stream_o0_valid", o0_valid, 1'b1);
            chk1("stream_o1_valid", o1_valid, 1'b1);
            chkd("stream_o0_data", o0_data, k);
            chkd("stream_o1_data", o1_data, k);
        end
        i_valid = 1'b0;
        tick();
        chk1("stream_end_o0_valid", o0_valid, 1'b0);
        chk1("stream_end_o1_valid", o1_valid, 1'b0);

        // Stall branch 1 and offer 0xA, 0xB, 0xC
        o1_ready = 1'b0;
        o0_ready = 1'b1;
        i_valid  = 1'b1;
        i_data   = 32'hA;
        #1;
        chk1("stall_a_i_ready", i_ready, 1'b1);
        tick();
        chkd("stall_a_o0_data", o0_data, 32'hA);
        chkd("stall_a_o1_data", o1_data, 32'hA);
        chkc("stall_a_c1", dut.u_skid1.count, 2'd1);
        i_data = 32'hB;
        #1;
        chk1("stall_b_i_ready", i_ready, 1'b1);
        tick();
        chkd("stall_b_o0_data", o0_data, 32'hB);
        chkd("stall_b_o1_data", o1_data, 32'hA);
        chkc("stall_b_c1", dut.u_skid1.count, 2'd2);
        i_data = 32'hC;
        #1;
        chk1("stall_c_i_ready", i_ready, 1'b0);
        tick();
        chk1("stall_c_i_ready_hold", i_ready, 1'b0);
        chk1("stall_c_o0_valid", o0_valid, 1'b0);
        chk1("stall_c_o1_valid", o1_valid, 1'b1);
        chkd("stall_c_o1_data", o1_data, 32'hA);
        chkc("stall_c_c1", dut.u_skid1.count, 2'd2);

        // Release branch 1 while 0xC is still offered
        o1_ready = 1'b1;
        #1;
        chk1("rel_i_ready_blocked", i_ready, 1'b0);
        tick();
        chkd("rel_o1_data_b", o1_data, 32'hB);
        chk1("rel_o0_valid_empty", o0_valid, 1'b0);
        chk1("rel_i_ready_open", i_ready, 1'b1);
        tick();
        chkd("rel_o1_data_c", o1_data, 32'hC);
        chkd("rel_o0_data_c", o0_data, 32'hC);
        chk1("rel_o0_valid_c", o0_valid, 1'b1);
        chkc("rel_c1", dut.u_skid1.count, 2'd1);
        i_valid = 1'b0;
        tick();
        chk1("rel_end_o0_valid", o0_valid, 1'b0);
        chk1("rel_end_o1_valid", o1_valid, 1'b0);

        // Hold stability on branch 0
        o0_ready = 1'b0;
        o1_ready = 1'b1;
        i_valid  = 1'b1;
        i_data   = 32'h55;
        tick();
        i_valid = 1'b0;
        i_data  = 32'hDEAD;
        for (int i = 0; i < 5; i++) begin
            chk1("hold_o0_valid", o0_valid, 1'b1);
            chkd("hold_o0_data", o0_data, 32'h55);
            tick();
        end
        chk1("hold_o1_drained", o1_valid, 1'b0);
        o0_ready = 1'b1;
        tick();
        chk1("hold_done_o0_valid", o0_valid, 1'b0);

        // Fill both buffers, then pulse reset for one cycle
        o0_ready = 1'b0;
        o1_ready = 1'b0;
        i_valid  = 1'b1;
        i_data   = 32'h11;
        tick();
        i_data = 32'h22;
        tick();
        i_valid = 1'b0;
        chkc("full_c0", dut.u_skid0.count, 2'd2);
        chkc("full_c1", dut.u_skid1.count, 2'd2);
        chk1("full_i_ready", i_ready, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk1("mrst_o0_valid", o0_valid, 1'b0);
        chk1("mrst_o1_valid", o1_valid, 1'b0);
        chkd("mrst_o0_data", o0_data, 32'h0);
        chk1("mrst_i_ready", i_ready, 1'b1);
        o0_ready = 1'b1;
        o1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("mrst_no_stale_o0", o0_valid, 1'b0);
            chk1("mrst_no_stale_o1", o1_valid, 1'b0);
        end
        i_valid = 1'b1;
        i_data  = 32'h33;
        tick();
        i_valid = 1'b0;
        chkd("mrst_new_o0_data", o0_data, 32'h33);
        chkd("mrst_new_o1_data", o1_data, 32'h33);
        tick();
        chk1("mrst_final_o0_valid", o0_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_fork2.md
STREAM_FORK2 -- requirements
Module: stream_fork2

Interface
REQ-001 The module SHALL have parameter DW, default 32, giving the payload width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port i_valid, input, 1 bit: upstream beat offered.
REQ-005 The module SHALL have port i_ready, output, 1 bit: upstream beat accepted when high together with i_valid.
REQ-006 The module SHALL have port i_data, input, DW bits: upstream payload.
REQ-007 The module SHALL have ports o0_valid / o1_valid, output, 1 bit each: branch beat offered.
REQ-008 The module SHALL have ports o0_ready / o1_ready, input, 1 bit each: branch beat accepted.
REQ-009 The module SHALL have ports o0_data / o1_data, output, DW bits each: branch payload.

Function
REQ-010 The module SHALL duplicate every accepted input beat onto both branches exactly once, in order; it is the fork counterpart of a valid-AND join.
REQ-011 Each branch SHALL own a 2-entry FIFO buffer with count cN in {0,1,2}.
REQ-012 Input transfer SHALL occur iff i_valid && i_ready; it pushes i_data into both buffers in the same cycle.
REQ-013 i_ready SHALL be high iff c0 < 2 && c1 < 2 and reset_n is high; it SHALL have no combinational path from o0_ready, o1_ready or i_valid.
REQ-014 oN_valid SHALL equal (cN > 0); oN_data SHALL equal the buffer head; both are driven from registers.
REQ-015 Branch pop SHALL occur iff oN_valid && oN_ready; the branches drain independently.
REQ-016 Latency SHALL be 1 cycle: a beat accepted at edge k appears on an empty branch after edge k.
REQ-017 With cN = 1, a simultaneous push and pop SHALL leave cN = 1 with the new beat at the head.
REQ-018 With cN = 0, a push SHALL set cN = 1; no bypass of the buffer is allowed.
REQ-019 With cN = 2, no push can occur (REQ-013); a pop SHALL set cN = 1 and advance the head.
REQ-020 Sustained throughput SHALL be 1 beat/cycle when both branches hold oN_ready high.
REQ-021 A stalled branch SHALL block new input after at most 2 buffered beats; the other branch SHALL still drain its buffered beats.
REQ-022 oN_valid SHALL not drop, and oN_data SHALL not change, while oN_valid && !oN_ready.

Reset
REQ-023 While reset_n is low at a clk edge: c0 = c1 = 0, o0_valid = o1_valid = 0, o0_data = o1_data = 0, and i_ready = 0.
REQ-024 Reset mid-operation SHALL discard all buffered beats without emitting them.
REQ-025 In the first cycle after reset_n rises, i_ready SHALL be 1.

Structure
REQ-026 The 2-entry buffer SHALL be a sub-module stream_skid2 (ports: clk, reset_n, push, pop, din, dout, count), instantiated once per branch.
REQ-027 Package stream_pkg SHALL hold typedef cnt2_t (2-bit count) and constant SKID_DEPTH = 2; both modules import it.
REQ-028 Top-level logic SHALL be limited to i_ready generation and the push/pop strobes.

Verification
REQ-029 Reset: hold reset_n = 0 for 3 cycles with i_valid = 1 -> i_ready = 0 and oN_valid = 0 throughout; i_ready = 1 on the first cycle after release.
REQ-030 Streaming: send 0x1..0x10 with both readys high -> each branch outputs 0x1..0x10 in order, one per cycle, first beat 1 cycle after acceptance.
REQ-031 Stall: hold o1_ready = 0 and send 0xA, 0xB, 0xC -> 0xA and 0xB accepted, i_ready = 0 while 0xC is offered; o0 emits 0xA, 0xB; c1 = 2.
REQ-032 Stall release: from the REQ-031 state, raise o1_ready -> o1 emits 0xA, 0xB, then 0xC; o0 also emits 0xC; no duplicate or lost beats.
REQ-033 Hold stability: o0_valid = 1 with o0_ready = 0 for 5 cycles -> o0_data is constant (e.g. 0x55) and o0_valid stays 1.
REQ-034 Mid-operation reset: with c0 = c1 = 2, pulse reset_n low for 1 cycle -> both oN_valid = 0 next cycle, and no stale beat appears afterwards.
